// File: rtl/grf_write_port.sv
// grf_write_port: merges the in-order writeback stream and the out-of-order
// mult/div result stream onto the single GRF write port. The pipeline always
// wins the port. Mult/div results wait in a small FIFO. A FIFO entry is
// killed when a younger writeback targets the same register. Decode is told
// which source registers still have a write pending in the FIFO.
module grf_write_port #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        stall_GRF,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    input  logic [31:0] md_pc,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        pend_rs,
    output logic        pend_rt,
    output logic        RegWr,
    output logic [4:0]  RWAddr,
    output logic [31:0] RWData,
    output logic [31:0] PC
);

    // Handshake: a mult/div result transfers on any rising edge where
    // md_valid & md_ready are both high. md_ready depends only on occupancy.
    // Results for $0 complete the handshake but are dropped.

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // FIFO storage (payload is not reset; valid/kill bits are)
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      epc_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] kill_q;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    // Output stage
    logic        regwr_q;
    logic [4:0]  rwaddr_q;
    logic [31:0] rwdata_q;
    logic [31:0] pc_q;

    logic push, store, wb_issue, pop, head_killed;

    // Slot arbitration and FIFO pointer/occupancy next state
    always_comb begin
        md_ready    = (count_q < FULL_CNT);
        push        = md_valid & md_ready;
        store       = push & (md_addr != 5'd0);
        wb_issue    = ~stall_GRF & wb_valid & (wb_addr != 5'd0);
        pop         = ~stall_GRF & ~wb_issue & (count_q != '0);
        head_killed = kill_q[head_q];

        head_d  = pop   ? head_q + PTR_ONE : head_q;
        tail_d  = store ? tail_q + PTR_ONE : tail_q;
        count_d = count_q;
        if (store && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!store && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pending-write lookup over live (stored, not killed) entries
    always_comb begin
        pend_rs = 1'b0;
        pend_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !kill_q[i]) begin
                if (addr_q[i] == rs) pend_rs = 1'b1;
                if (addr_q[i] == rt) pend_rt = 1'b1;
            end
        end
        if (rs == 5'd0) pend_rs = 1'b0;
        if (rt == 5'd0) pend_rt = 1'b0;
    end

    // FIFO payload write at the tail
    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[tail_q] <= md_addr;
            data_q[tail_q] <= md_data;
            epc_q[tail_q]  <= md_pc;
        end
    end

    // FIFO control: pointers, count, valid and kill bits
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            kill_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // A WB to the same register supersedes every older MD entry
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_issue && valid_q[i] && (addr_q[i] == wb_addr)) begin
                    kill_q[i] <= 1'b1;
                end
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                kill_q[head_q]  <= 1'b0;
            end
            // Written last so an entry pushed this cycle starts un-killed
            if (store) begin
                valid_q[tail_q] <= 1'b1;
                kill_q[tail_q]  <= 1'b0;
            end
        end
    end

    // Registered GRF write stage; address/data/PC hold when no write issues
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            regwr_q  <= 1'b0;
            rwaddr_q <= 5'd0;
            rwdata_q <= 32'd0;
            pc_q     <= 32'd0;
        end else if (!stall_GRF) begin
            if (wb_issue) begin
                regwr_q  <= 1'b1;
                rwaddr_q <= wb_addr;
                rwdata_q <= wb_data;
                pc_q     <= wb_pc;
            end else if (pop && !head_killed) begin
                regwr_q  <= 1'b1;
                rwaddr_q <= addr_q[head_q];
                rwdata_q <= data_q[head_q];
                pc_q     <= epc_q[head_q];
            end else begin
                regwr_q  <= 1'b0;
            end
        end
    end

    assign RegWr  = regwr_q;
    assign RWAddr = rwaddr_q;
    assign RWData = rwdata_q;
    assign PC     = pc_q;

endmodule

// File: tb/tb_grf_write_port.sv
// Bench for grf_write_port: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the write port.
module tb_grf_write_port;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        Reset;
  logic        stall_GRF;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic [31:0] md_pc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        pend_rs;
  logic        pend_rt;
  logic        RegWr;
  logic [4:0]  RWAddr;
  logic [31:0] RWData;
  logic [31:0] PC;

  grf_write_port #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .Reset(Reset), .stall_GRF(stall_GRF),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr),
    .md_data(md_data), .md_pc(md_pc), .rs(rs), .rt(rt),
    .pend_rs(pend_rs), .pend_rt(pend_rt), .RegWr(RegWr),
    .RWAddr(RWAddr), .RWData(RWData), .PC(PC)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: pending MD results in push order
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    bit          killed;
  } md_ent_t;

  md_ent_t     md_q[$];
  logic        exp_regwr;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (md_q[i]) begin
      if (!md_q[i].killed && md_q[i].addr == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_comb(input string tag);
    chk({tag, ".md_ready"}, 32'(md_ready), 32'(md_q.size() < DEPTH));
    chk({tag, ".pend_rs"}, 32'(pend_rs), 32'(model_pend(rs)));
    chk({tag, ".pend_rt"}, 32'(pend_rt), 32'(model_pend(rt)));
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".RegWr"}, 32'(RegWr), 32'(exp_regwr));
    chk({tag, ".RWAddr"}, 32'(RWAddr), 32'(exp_addr));
    chk({tag, ".RWData"}, RWData, exp_data);
    chk({tag, ".PC"}, PC, exp_pc);
    chk({tag, ".no_wr_r0"}, 32'(RegWr && RWAddr == 5'd0), 32'd0);
  endtask

  // driver tasks
  task automatic drive(input bit stl, input bit wbv, input logic [4:0] wba,
                       input logic [31:0] wbd, input logic [31:0] wbp,
                       input bit mdv, input logic [4:0] mda,
                       input logic [31:0] mdd, input logic [31:0] mdp,
                       input logic [4:0] r_s, input logic [4:0] r_t);
    stall_GRF = stl; wb_valid = wbv; wb_addr = wba; wb_data = wbd; wb_pc = wbp;
    md_valid = mdv; md_addr = mda; md_data = mdd; md_pc = mdp; rs = r_s; rt = r_t;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
  endtask

  // One clock: check combinational outputs, step the model, check outputs.
  // Entered and left at posedge+1.
  task automatic cycle(input string tag);
    bit push;
    bit s, wv, mv;
    logic [4:0] wa, ma;
    logic [31:0] wd, wp, md, mp;
    md_ent_t e;
    #1;
    check_comb(tag);
    s = stall_GRF; wv = wb_valid; wa = wb_addr; wd = wb_data; wp = wb_pc;
    mv = md_valid; ma = md_addr; md = md_data; mp = md_pc;
    push = mv && (md_q.size() < DEPTH);
    @(posedge clk);
    if (!s) begin
      if (wv && wa != 5'd0) begin
        exp_regwr = 1'b1; exp_addr = wa; exp_data = wd; exp_pc = wp;
        foreach (md_q[i]) if (md_q[i].addr == wa) md_q[i].killed = 1'b1;
      end else if (md_q.size() > 0) begin
        e = md_q.pop_front();
        if (!e.killed) begin
          exp_regwr = 1'b1; exp_addr = e.addr; exp_data = e.data; exp_pc = e.pc;
        end else begin
          exp_regwr = 1'b0;
        end
      end else begin
        exp_regwr = 1'b0;
      end
    end
    if (push && ma != 5'd0) md_q.push_back('{ma, md, mp, 1'b0});
    #1;
    check_out(tag);
  endtask

  // Asynchronous reset applied mid-cycle; entered and left at posedge+1
  task automatic do_reset(input string tag);
    #2;
    Reset = 1'b0;
    md_q.delete();
    exp_regwr = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_pc = 32'd0;
    #1;
    check_out({tag, ".async"});
    check_comb({tag, ".async"});
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    check_out({tag, ".released"});
  endtask

  initial begin
    Reset = 1'b0;
    idle_in();
    exp_regwr = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_pc = 32'd0;
    @(posedge clk);
    #1;
    check_out("por");
    check_comb("por");
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk);
    #1;

    // pipeline writeback lands one edge later
    drive(0, 1, 5'd5, 32'h0000_1234, 32'h0000_3000, 0, 0, 0, 0, 0, 0);
    cycle("wb5");
    chk("wb5.addr_const", 32'(RWAddr), 32'd5);
    chk("wb5.data_const", RWData, 32'h0000_1234);

    // fill the FIFO while WB owns every slot, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 5'(16 + i), 32'h100 + i, 32'h200 + i, 1, 5'(i), 32'hA00 + i, 32'hB00 + i, 5'(i), 5'd3);
      cycle("fill");
    end
    drive(0, 1, 5'd21, 32'h1, 32'h2, 1, 5'd7, 32'h7, 32'h7, 5'd4, 5'd1);
    #1;
    chk("full.md_ready", 32'(md_ready), 32'd0);
    chk("full.pend_rs", 32'(pend_rs), 32'd1);
    cycle("full");
    idle_in();
    for (int i = 1; i <= 4; i++) begin
      cycle("drain");
      chk("drain.order", 32'(RWAddr), 32'(i));
    end

    // reset in the middle of draining three entries
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 5'd30, 32'h5, 32'h6, 1, 5'(10 + i), $urandom, $urandom, 0, 0);
      cycle("pre_rst");
    end
    idle_in();
    cycle("pre_rst_drain");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd11, 5'd12);
    do_reset("rst_mid");

    // younger WB kills the queued MD write to the same register
    drive(0, 1, 5'd20, 32'h1, 32'h1, 1, 5'd8, 32'h0000_AAAA, 32'h40, 5'd8, 5'd0);
    cycle("kill_push");
    drive(0, 1, 5'd8, 32'h0000_BBBB, 32'h44, 0, 0, 0, 0, 5'd8, 5'd0);
    #1;
    chk("kill.pend_before", 32'(pend_rs), 32'd1);
    cycle("kill_wb");
    chk("kill.pend_after", 32'(pend_rs), 32'd0);
    idle_in();
    rs = 5'd8;
    cycle("kill_slot");
    chk("kill.slot_regwr", 32'(RegWr), 32'd0);
    chk("kill.last_data", RWData, 32'h0000_BBBB);

    // stall holds the output stage; pushes still land
    drive(0, 1, 5'd9, 32'h99, 32'h900, 0, 0, 0, 0, 0, 0);
    cycle("pre_stall");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'd13, 32'h13, 32'h1300, 1, 5'(24 + i), $urandom, $urandom, 5'(24 + i), 5'd9);
      cycle("stall");
      chk("stall.hold_addr", 32'(RWAddr), 32'd9);
      chk("stall.hold_wr", 32'(RegWr), 32'd1);
    end
    idle_in();
    for (int i = 0; i < 4; i++) cycle("post_stall");

    // $0 requests never write and never occupy the FIFO
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 5'd0, 32'hDEAD, 32'hBEEF, 1, 5'd0, 32'hCAFE, 32'hF00D, 0, 0);
      #1;
      chk("zero.md_ready", 32'(md_ready), 32'd1);
      cycle("zero");
      chk("zero.regwr", 32'(RegWr), 32'd0);
    end

    // random traffic with a narrow register range to force collisions
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
            $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle("rand");
      if (n == 200) begin
        idle_in();
        do_reset("rst_rand");
      end
    end
    idle_in();
    for (int i = 0; i < 6; i++) cycle("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
